display_16hex_capture: RTL and testbench
========================================

// Module: display_16hex_capture
// PURPOSE
//  Receive end of the labkit hex dot-matrix serial interface: samples disp_clock/disp_data/
//  disp_rs/disp_ce_b/disp_reset_b as produced by the 16-digit hex driver and recovers the
//  displayed value. Each 40-bit glyph is decoded back to its hex nibble against the driver font.
//  Latched control words are also recovered. Used as an on-chip monitor and as the bench
//  checker for the display path.
// PARAMETERS
//  SYNC_STAGES  2   synchroniser depth on every disp_* input (>=2)
//  NUM_CHARS    16  glyphs per frame; frame = NUM_CHARS*40 dot bits
// PORTS
//  clock_27mhz    in   1   system clock, >=20x disp_clock rate
//  reset_b        in   1   synchronous, active-low reset
//  disp_clock     in   1   serial clock; data sampled on its rising edge
//  disp_data      in   1   serial data, MSB (dot 39 of char 15) first
//  disp_rs        in   1   0 = dot register, 1 = control register
//  disp_ce_b      in   1   active-low chip enable; rising edge = latch
//  disp_reset_b   in   1   active-low display reset
//  data_out       out  64  recovered nibbles, char 15 in [63:60]
//  char_ok        out  16  bit i = glyph i matched the font
//  frame_valid    out  1   1-cycle pulse: data_out/char_ok updated
//  frame_err      out  1   1-cycle pulse: dot latch with bad bit count
//  control_out    out  32  last latched control word
//  ctrl_valid     out  1   1-cycle pulse: control_out updated
// BEHAVIOUR
//  - Reset (reset_b=0 at clock edge): all outputs 0, accumulators/counters 0, sync chains 0
//    except ce_b/reset_b chains which load 1 (idle).
//  - Inputs pass through SYNC_STAGES flops; edges detected on synchronised value vs 1 cycle prior.
//  - Shift: synchronised disp_clock 0->1 with ce_b_s=0. rs_s=0: bit into 40-bit glyph shift reg,
//    bit_cnt+1 (10 bits, saturates 1023). rs_s=1: bit into 32-bit ctrl shift reg, ctrl_cnt+1 (sat 63).
//  - Glyph complete (40th bit of a glyph): combinational font compare (0-F, driver font) ->
//    nib_acc <= {nib_acc[59:0],nib}, ok_acc <= {ok_acc[14:0],match}; no match -> nib 0, match 0.
//    More than NUM_CHARS glyphs: older ones fall off the top (last 16 kept, as the display does).
//  - Latch: ce_b_s 0->1. rs_s=0: if bit_cnt>=640 and bit_cnt%40==0 -> data_out<=nib_acc,
//    char_ok<=ok_acc, frame_valid pulse; else frame_err pulse, outputs unchanged.
//    rs_s=1: ctrl_cnt==32 -> control_out<=ctrl shift, ctrl_valid pulse; else frame_err pulse.
//    Both cases then clear bit_cnt/ctrl_cnt and glyph bit counter.
//  - Latency: outputs/pulses register 1 clock after the cycle the latch edge is detected
//    (SYNC_STAGES+2 clocks after the pin edge).
//  - Simultaneous clock rise and ce_b rise in one sampled cycle: ce_b_s already 1, shift discarded.
//  - rs change while ce_b_s=0: counts of both registers kept; latch uses rs_s at latch time.
//  - disp_reset_b_s=0: clear accumulators, counters, data_out, char_ok; control_out kept.
//    No pulses; shifts ignored while low.
//  - reset_b mid-frame: partial frame discarded, no pulse.
//  - All-zero glyph (driver init pattern) is not a match: char_ok bit 0.
// CONFIGURATION
//  DISPLAY_16HEX_CAPTURE_RAW_EN defined: extra output raw_dots[NUM_CHARS*40-1:0] = last
//    NUM_CHARS*40 dot bits, loaded with data_out on frame_valid, cleared on either reset.
//  Undefined: port absent; only the 40-bit glyph shift register is kept.
// TESTING
//  1 Driver-model frame data=64'h0123456789ABCDEF -> frame_valid once, data_out=0123456789ABCDEF, char_ok=FFFF.
//  2 Init: disp_reset_b pulse, 640 zero bits, latch rs=0 -> data_out=0, char_ok=0000, frame_valid once.
//  3 Control: rs=1, 32 bits of 32'h7F7F7F7F, latch -> control_out=7F7F7F7F, ctrl_valid once, data_out unchanged.
//  4 Bad counts: latch after 639 dot bits -> frame_err, data_out held; 31 ctrl bits -> frame_err.
//  5 680 bits (glyph 'F' then frame for 64'hFEDCBA9876543210) -> data_out=FEDCBA9876543210.
//  6 reset_b=0 after 200 bits, then a full frame -> only full frame reported; glyph 'A' with dot 0 flipped -> char_ok bit 0.

Source files
------------

// File: rtl/display_16hex_capture.sv
// display_16hex_capture: receive side of the 16-digit hex dot-matrix serial link; recovers nibbles and control words.
// Define DISPLAY_16HEX_CAPTURE_RAW_EN to add raw_dots, the dot bits of the last accepted frame.
module display_16hex_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CHARS   = 16
) (
    input  logic        clock_27mhz,
    input  logic        reset_b,
    input  logic        disp_clock,
    input  logic        disp_data,
    input  logic        disp_rs,
    input  logic        disp_ce_b,
    input  logic        disp_reset_b,
    output logic [63:0] data_out,
    output logic [15:0] char_ok,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [31:0] control_out,
    output logic        ctrl_valid
`ifdef DISPLAY_16HEX_CAPTURE_RAW_EN
    ,
    output logic [NUM_CHARS*40-1:0] raw_dots
`endif
);

    localparam logic [9:0] FRAME_BITS = 10'(NUM_CHARS * 40);
    // Chain bit order {reset_b, ce_b, rs, data, clock}; the active-low pins idle high
    localparam logic [4:0] SYNC_IDLE  = 5'b11000;

    logic [4:0]  sync_r [SYNC_STAGES];
    logic        clk_s, data_s, rs_s, ce_b_s, dreset_b_s;
    logic        clk_prev_r, ce_b_prev_r;
    logic        shift_det_s, latch_det_s;
    logic        shift_ev_r, latch_ev_r, bit_ev_r, rs_ev_r;
    logic [39:0] glyph_sh_r, glyph_next_s;
    logic [5:0]  glyph_cnt_r;
    logic [9:0]  bit_cnt_r;
    logic [31:0] ctrl_sh_r;
    logic [5:0]  ctrl_cnt_r;
    logic [63:0] nib_acc_r;
    logic [15:0] ok_acc_r;
    logic [4:0]  glyph_dec_s;
    logic        frame_ok_s;

    // Font lookup: {match, nibble}; anything outside the driver font, including all-zero, is no match
    function automatic logic [4:0] glyph_decode(input logic [39:0] dots);
        logic [4:0] res;
        case (dots)
            40'h3E5149453E: res = {1'b1, 4'h0};
            40'h00427F4000: res = {1'b1, 4'h1};
            40'h6251494946: res = {1'b1, 4'h2};
            40'h2241494936: res = {1'b1, 4'h3};
            40'h1814127F10: res = {1'b1, 4'h4};
            40'h2745454539: res = {1'b1, 4'h5};
            40'h3C4A494930: res = {1'b1, 4'h6};
            40'h0171090503: res = {1'b1, 4'h7};
            40'h3649494936: res = {1'b1, 4'h8};
            40'h064949291E: res = {1'b1, 4'h9};
            40'h7E0909097E: res = {1'b1, 4'hA};
            40'h7F49494936: res = {1'b1, 4'hB};
            40'h3E41414122: res = {1'b1, 4'hC};
            40'h7F4141413E: res = {1'b1, 4'hD};
            40'h7F49494941: res = {1'b1, 4'hE};
            40'h7F09090901: res = {1'b1, 4'hF};
            default:        res = 5'b0_0000;
        endcase
        return res;
    endfunction

    // Synchroniser chains for every disp_* pin
    always_ff @(posedge clock_27mhz) begin
        if (!reset_b) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= SYNC_IDLE;
        end else begin
            sync_r[0] <= {disp_reset_b, disp_ce_b, disp_rs, disp_data, disp_clock};
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    // Edge detection on synchronised pins and font compare of the glyph being completed
    always_comb begin
        clk_s        = sync_r[SYNC_STAGES-1][0];
        data_s       = sync_r[SYNC_STAGES-1][1];
        rs_s         = sync_r[SYNC_STAGES-1][2];
        ce_b_s       = sync_r[SYNC_STAGES-1][3];
        dreset_b_s   = sync_r[SYNC_STAGES-1][4];
        // A clock rise seen together with ce_b already high is discarded
        shift_det_s  = dreset_b_s & clk_s & ~clk_prev_r & ~ce_b_s;
        latch_det_s  = dreset_b_s & ce_b_s & ~ce_b_prev_r;
        glyph_next_s = {glyph_sh_r[38:0], bit_ev_r};
        glyph_dec_s  = glyph_decode(glyph_next_s);
        frame_ok_s   = (bit_cnt_r >= FRAME_BITS) && ((bit_cnt_r % 10'd40) == 10'd0);
    end

    // Event stage: previous pin values and the detected shift/latch strobes with their data
    always_ff @(posedge clock_27mhz) begin
        if (!reset_b) begin
            clk_prev_r  <= 1'b0;
            ce_b_prev_r <= 1'b1;
            shift_ev_r  <= 1'b0;
            latch_ev_r  <= 1'b0;
            bit_ev_r    <= 1'b0;
            rs_ev_r     <= 1'b0;
        end else begin
            clk_prev_r  <= clk_s;
            ce_b_prev_r <= ce_b_s;
            shift_ev_r  <= shift_det_s;
            latch_ev_r  <= latch_det_s;
            bit_ev_r    <= data_s;
            rs_ev_r     <= rs_s;
        end
    end

    // Shift registers, glyph accumulation and latch handling
    always_ff @(posedge clock_27mhz) begin
        if (!reset_b) begin
            glyph_sh_r  <= 40'd0;
            glyph_cnt_r <= 6'd0;
            bit_cnt_r   <= 10'd0;
            ctrl_sh_r   <= 32'd0;
            ctrl_cnt_r  <= 6'd0;
            nib_acc_r   <= 64'd0;
            ok_acc_r    <= 16'd0;
            data_out    <= 64'd0;
            char_ok     <= 16'd0;
            control_out <= 32'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            ctrl_valid  <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            ctrl_valid  <= 1'b0;
            if (!dreset_b_s) begin
                // Display reset wipes the dot path; the last control word stays visible
                glyph_sh_r  <= 40'd0;
                glyph_cnt_r <= 6'd0;
                bit_cnt_r   <= 10'd0;
                ctrl_sh_r   <= 32'd0;
                ctrl_cnt_r  <= 6'd0;
                nib_acc_r   <= 64'd0;
                ok_acc_r    <= 16'd0;
                data_out    <= 64'd0;
                char_ok     <= 16'd0;
            end else if (latch_ev_r) begin
                if (!rs_ev_r) begin
                    if (frame_ok_s) begin
                        data_out    <= nib_acc_r;
                        char_ok     <= ok_acc_r;
                        frame_valid <= 1'b1;
                    end else begin
                        frame_err   <= 1'b1;
                    end
                end else begin
                    if (ctrl_cnt_r == 6'd32) begin
                        control_out <= ctrl_sh_r;
                        ctrl_valid  <= 1'b1;
                    end else begin
                        frame_err   <= 1'b1;
                    end
                end
                bit_cnt_r   <= 10'd0;
                ctrl_cnt_r  <= 6'd0;
                glyph_cnt_r <= 6'd0;
            end else if (shift_ev_r) begin
                if (!rs_ev_r) begin
                    glyph_sh_r <= glyph_next_s;
                    if (bit_cnt_r != 10'd1023) bit_cnt_r <= bit_cnt_r + 10'd1;
                    if (glyph_cnt_r == 6'd39) begin
                        glyph_cnt_r <= 6'd0;
                        nib_acc_r   <= {nib_acc_r[59:0], glyph_dec_s[3:0]};
                        ok_acc_r    <= {ok_acc_r[14:0], glyph_dec_s[4]};
                    end else begin
                        glyph_cnt_r <= glyph_cnt_r + 6'd1;
                    end
                end else begin
                    ctrl_sh_r <= {ctrl_sh_r[30:0], bit_ev_r};
                    if (ctrl_cnt_r != 6'd63) ctrl_cnt_r <= ctrl_cnt_r + 6'd1;
                end
            end
        end
    end

`ifdef DISPLAY_16HEX_CAPTURE_RAW_EN
    logic [NUM_CHARS*40-1:0] raw_sh_r;

    // Raw dot history, published together with data_out on an accepted frame
    always_ff @(posedge clock_27mhz) begin
        if (!reset_b || !dreset_b_s) begin
            raw_sh_r <= {(NUM_CHARS*40){1'b0}};
            raw_dots <= {(NUM_CHARS*40){1'b0}};
        end else if (latch_ev_r && !rs_ev_r && frame_ok_s) begin
            raw_dots <= raw_sh_r;
        end else if (shift_ev_r && !rs_ev_r) begin
            raw_sh_r <= {raw_sh_r[NUM_CHARS*40-2:0], bit_ev_r};
        end
    end
`endif

endmodule

// File: tb/tb_display_16hex_capture.sv
// Scoreboard bench for display_16hex_capture: a driver model sends frames/control words,
// a glyph-level reference model predicts each pulse, a monitor compares on every pulse.
module tb_display_16hex_capture;

    logic        clock_27mhz;
    logic        reset_b;
    logic        disp_clock, disp_data, disp_rs, disp_ce_b, disp_reset_b;
    logic [63:0] data_out;
    logic [15:0] char_ok;
    logic        frame_valid, frame_err, ctrl_valid;
    logic [31:0] control_out;
`ifdef DISPLAY_16HEX_CAPTURE_RAW_EN
    logic [639:0] raw_dots;
`endif

    display_16hex_capture #(.SYNC_STAGES(2), .NUM_CHARS(16)) dut (
        .clock_27mhz (clock_27mhz),
        .reset_b     (reset_b),
        .disp_clock  (disp_clock),
        .disp_data   (disp_data),
        .disp_rs     (disp_rs),
        .disp_ce_b   (disp_ce_b),
        .disp_reset_b(disp_reset_b),
        .data_out    (data_out),
        .char_ok     (char_ok),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .control_out (control_out),
        .ctrl_valid  (ctrl_valid)
`ifdef DISPLAY_16HEX_CAPTURE_RAW_EN
        ,
        .raw_dots    (raw_dots)
`endif
    );

    initial begin
        clock_27mhz = 1'b0;
        forever #5 clock_27mhz = ~clock_27mhz;
    end

    // Driver font, column bytes left to right, dot 39 first on the wire
    logic [39:0] font [16] = '{
        40'h3E5149453E, 40'h00427F4000, 40'h6251494946, 40'h2241494936,
        40'h1814127F10, 40'h2745454539, 40'h3C4A494930, 40'h0171090503,
        40'h3649494936, 40'h064949291E, 40'h7E0909097E, 40'h7F49494936,
        40'h3E41414122, 40'h7F4141413E, 40'h7F49494941, 40'h7F09090901};

    typedef struct packed {
        logic [1:0]  kind;   // 0 frame, 1 control, 2 error
        logic [63:0] data;
        logic [15:0] ok;
        logic [31:0] ctrl;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_failed = 0;

    // Reference model state
    logic [39:0] glyph_q[$];
    logic [39:0] part;
    int          part_cnt, dot_cnt, ctrl_cnt;
    logic [31:0] ctrl_val;
    logic [63:0] m_data;
    logic [15:0] m_ok;
    logic [31:0] m_ctrl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [39:0] g);
        for (int k = 0; k < 16; k++)
            if (font[k] == g) return {1'b1, 4'(k)};
        return 5'd0;
    endfunction

    task automatic model_clear_display();
        glyph_q.delete();
        for (int k = 0; k < 16; k++) glyph_q.push_back(40'd0);
        part = 40'd0; part_cnt = 0; dot_cnt = 0; ctrl_cnt = 0; ctrl_val = 32'd0;
        m_data = 64'd0; m_ok = 16'd0;
    endtask

    task automatic send_bit(input logic b, input logic rs);
        disp_clock = 1'b0; disp_data = b; disp_rs = rs;
        repeat (3) @(negedge clock_27mhz);
        disp_clock = 1'b1;
        repeat (3) @(negedge clock_27mhz);
        if (!rs) begin
            dot_cnt++;
            part = {part[38:0], b};
            part_cnt++;
            if (part_cnt == 40) begin
                glyph_q.push_back(part);
                glyph_q.pop_front();
                part_cnt = 0;
            end
        end else begin
            ctrl_cnt++;
            ctrl_val = {ctrl_val[30:0], b};
        end
    endtask

    task automatic begin_burst();
        disp_clock = 1'b0;
        disp_ce_b  = 1'b0;
        repeat (3) @(negedge clock_27mhz);
    endtask

    task automatic send_glyph(input logic [39:0] g);
        for (int d = 39; d >= 0; d--) send_bit(g[d], 1'b0);
    endtask

    task automatic send_frame(input logic [63:0] val, input int flip_char, input int flip_dot);
        logic [39:0] g;
        for (int c = 15; c >= 0; c--) begin
            g = font[val[c*4 +: 4]];
            if (c == flip_char) g[flip_dot] = ~g[flip_dot];
            send_glyph(g);
        end
    endtask

    task automatic send_ctrl(input logic [31:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(w[i], 1'b1);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            @(negedge clock_27mhz);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_tests++; n_failed++;
            $display("FAIL pulse_timeout: %0d expected pulses never seen", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic latch(input logic rs);
        exp_t e;
        int   cnt;
        logic [4:0] dec;
        disp_clock = 1'b0; disp_rs = rs;
        repeat (3) @(negedge clock_27mhz);
        if (!rs) begin
            cnt = (dot_cnt > 1023) ? 1023 : dot_cnt;
            if (cnt >= 640 && cnt % 40 == 0) begin
                m_data = 64'd0; m_ok = 16'd0;
                foreach (glyph_q[i]) begin
                    dec = ref_decode(glyph_q[i]);
                    m_data = {m_data[59:0], dec[3:0]};
                    m_ok   = {m_ok[14:0], dec[4]};
                end
                e.kind = 2'd0;
            end else begin
                e.kind = 2'd2;
            end
        end else begin
            if (ctrl_cnt == 32) begin
                m_ctrl = ctrl_val;
                e.kind = 2'd1;
            end else begin
                e.kind = 2'd2;
            end
        end
        e.data = m_data; e.ok = m_ok; e.ctrl = m_ctrl;
        exp_q.push_back(e);
        dot_cnt = 0; ctrl_cnt = 0; part_cnt = 0;
        disp_ce_b = 1'b1;
        wait_drain();
        repeat (4) @(negedge clock_27mhz);
    endtask

    // Monitor: every output pulse pops one prediction and checks all outputs against it
    always @(negedge clock_27mhz) begin
        if (reset_b && (frame_valid || frame_err || ctrl_valid)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {61'd0, frame_valid, ctrl_valid, frame_err}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", {61'd0, frame_valid, ctrl_valid, frame_err},
                      {61'd0, mon_e.kind == 2'd0, mon_e.kind == 2'd1, mon_e.kind == 2'd2});
                check("data_out", data_out, mon_e.data);
                check("char_ok", {48'd0, char_ok}, {48'd0, mon_e.ok});
                check("control_out", {32'd0, control_out}, {32'd0, mon_e.ctrl});
            end
        end
    end

    initial begin
        logic [63:0] rv;
        reset_b = 1'b0;
        disp_clock = 1'b0; disp_data = 1'b0; disp_rs = 1'b0; disp_ce_b = 1'b1; disp_reset_b = 1'b1;
        m_ctrl = 32'd0;
        model_clear_display();
        repeat (4) @(negedge clock_27mhz);
        check("reset_data_out", data_out, 64'd0);
        check("reset_char_ok", {48'd0, char_ok}, 64'd0);
        check("reset_control_out", {32'd0, control_out}, 64'd0);
        check("reset_pulses", {61'd0, frame_valid, ctrl_valid, frame_err}, 64'd0);
        reset_b = 1'b1;
        repeat (4) @(negedge clock_27mhz);

        // Full frame from the driver model
        begin_burst(); send_frame(64'h0123456789ABCDEF, -1, 0); latch(1'b0);

        // Display reset then the all-zero init pattern
        disp_reset_b = 1'b0;
        repeat (6) @(negedge clock_27mhz);
        disp_reset_b = 1'b1;
        model_clear_display();
        repeat (4) @(negedge clock_27mhz);
        check("dreset_data_out", data_out, 64'd0);
        begin_burst();
        for (int i = 0; i < 640; i++) send_bit(1'b0, 1'b0);
        latch(1'b0);

        // Control word
        begin_burst(); send_ctrl(32'h7F7F7F7F, 32); latch(1'b1);

        // Bad bit counts
        begin_burst();
        for (int i = 0; i < 639; i++) send_bit(1'b1, 1'b0);
        latch(1'b0);
        begin_burst(); send_ctrl(32'h12345678, 31); latch(1'b1);

        // 680 bits: the leading glyph falls off the top
        begin_burst(); send_glyph(font[15]); send_frame(64'hFEDCBA9876543210, -1, 0); latch(1'b0);

        // reset_b mid-frame discards the partial frame
        begin_burst();
        for (int i = 0; i < 200; i++) send_bit(1'($urandom_range(1)), 1'b0);
        reset_b = 1'b0; disp_clock = 1'b0; disp_ce_b = 1'b1;
        repeat (5) @(negedge clock_27mhz);
        reset_b = 1'b1;
        m_ctrl = 32'd0;
        model_clear_display();
        repeat (4) @(negedge clock_27mhz);
        check("midreset_data_out", data_out, 64'd0);
        check("midreset_control_out", {32'd0, control_out}, 64'd0);
        rv = {$urandom, $urandom};
        begin_burst(); send_frame(rv, -1, 0); latch(1'b0);

        // Glyph 'A' at char 0 with dot 0 flipped
        rv = {$urandom, $urandom};
        rv[3:0] = 4'hA;
        begin_burst(); send_frame(rv, 0, 0); latch(1'b0);

        // Randomised frames, corrupted glyphs and control words
        for (int it = 0; it < 5; it++) begin
            rv = {$urandom, $urandom};
            begin_burst();
            if ($urandom_range(1) == 1)
                send_frame(rv, int'($urandom_range(15)), int'($urandom_range(39)));
            else
                send_frame(rv, -1, 0);
            latch(1'b0);
            begin_burst(); send_ctrl($urandom, 32); latch(1'b1);
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
